// File: rtl/func_ret_rob.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | func_ret_rob : return-value reorder buffer, releases data in tag order |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module func_ret_rob #(
  parameter int RET_DW     = 32,
  parameter int CALL_SEQ_W = 2,
  parameter int INST_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           alloc_req,
  output logic                           alloc_gnt,
  output logic [CALL_SEQ_W-1:0]          alloc_seq,
  input  logic [INST_NUM-1:0]            ret_valid,
  input  logic [INST_NUM*CALL_SEQ_W-1:0] ret_seq,
  input  logic [INST_NUM*RET_DW-1:0]     ret_data,
  output logic [INST_NUM-1:0]            ret_ready,
  output logic                           out_valid,
  output logic [RET_DW-1:0]              out_data,
  input  logic                           out_ready,
  output logic [CALL_SEQ_W:0]            occupancy,
  output logic                           err
);

  localparam int DEPTH = 1 << CALL_SEQ_W;
  localparam logic [CALL_SEQ_W:0] c_full = {1'b1, {CALL_SEQ_W{1'b0}}};

  logic [CALL_SEQ_W-1:0] r_head;
  logic [CALL_SEQ_W-1:0] r_tail;
  logic [CALL_SEQ_W:0]   r_occ;
  logic [DEPTH-1:0]      r_alloc;
  logic [DEPTH-1:0]      r_done;
  logic [RET_DW-1:0]     r_mem [DEPTH];
  logic                  r_out_valid;
  logic [RET_DW-1:0]     r_out_data;
  logic                  r_err;

  logic [CALL_SEQ_W-1:0] w_seq  [INST_NUM];
  logic [RET_DW-1:0]     w_data [INST_NUM];
  logic [INST_NUM-1:0]   w_legal;
  logic [INST_NUM-1:0]   w_dup;
  logic [INST_NUM-1:0]   w_wr;
  logic [INST_NUM-1:0]   w_bad;
  logic                  w_retire;
  logic [CALL_SEQ_W-1:0] w_head_nxt;
  logic [DEPTH-1:0]      w_alloc_nxt;
  logic [DEPTH-1:0]      w_done_nxt;
  logic [RET_DW-1:0]     w_out_data_nxt;

  generate
    for (genvar g = 0; g < INST_NUM; g++) begin : g_chan
      assign w_seq[g]   = ret_seq[g*CALL_SEQ_W +: CALL_SEQ_W];
      assign w_data[g]  = ret_data[g*RET_DW +: RET_DW];
      assign w_legal[g] = ret_valid[g] && r_alloc[w_seq[g]] && !r_done[w_seq[g]];
    end
  endgenerate

  // Lowest-index channel wins when several present the same tag.
  always_comb begin
    w_dup = '0;
    for (int i = 1; i < INST_NUM; i++) begin
      for (int j = 0; j < i; j++) begin
        if (ret_valid[j] && (w_seq[j] == w_seq[i])) begin
          w_dup[i] = 1'b1;
        end
      end
    end
  end

  assign w_wr      = w_legal & ~w_dup;
  assign w_bad     = ret_valid & ~w_legal;
  assign ret_ready = rstn ? (w_wr | w_bad) : '0;

  // Full is judged on registered occupancy only; a same-cycle retire does not help.
  assign alloc_gnt = rstn && alloc_req && (r_occ < c_full);
  assign alloc_seq = r_tail;

  assign w_retire   = r_out_valid && out_ready;
  assign w_head_nxt = w_retire ? r_head + 1'b1 : r_head;

  always_comb begin
    w_alloc_nxt = r_alloc;
    w_done_nxt  = r_done;
    if (w_retire) begin
      w_alloc_nxt[r_head] = 1'b0;
      w_done_nxt[r_head]  = 1'b0;
    end
    if (alloc_gnt) begin
      w_alloc_nxt[r_tail] = 1'b1;
    end
    for (int i = 0; i < INST_NUM; i++) begin
      if (w_wr[i]) begin
        w_done_nxt[w_seq[i]] = 1'b1;
      end
    end
  end

  // Forward a same-cycle write into the next head slot so latency stays at one cycle.
  always_comb begin
    w_out_data_nxt = r_mem[w_head_nxt];
    for (int i = 0; i < INST_NUM; i++) begin
      if (w_wr[i] && (w_seq[i] == w_head_nxt)) begin
        w_out_data_nxt = w_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_alloc     <= '0;
      r_done      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_alloc     <= w_alloc_nxt;
      r_done      <= w_done_nxt;
      r_head      <= w_head_nxt;
      r_out_valid <= w_done_nxt[w_head_nxt];
      if (w_done_nxt[w_head_nxt]) begin
        r_out_data <= w_out_data_nxt;
      end
      if (alloc_gnt) begin
        r_tail <= r_tail + 1'b1;
      end
      case ({alloc_gnt, w_retire})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (|w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Data storage carries no reset; stale slots are never marked done.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INST_NUM; i++) begin
      if (w_wr[i]) begin
        r_mem[w_seq[i]] <= w_data[i];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign occupancy = r_occ;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_func_ret_rob.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_func_ret_rob : vector table, corner sequences and random vs model   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_func_ret_rob;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int NI = 4;
  localparam int DEPTH = 4;
  localparam int NV = 30;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            alloc_req = 1'b0;
  logic            alloc_gnt;
  logic [SW-1:0]   alloc_seq;
  logic [NI-1:0]   ret_valid = '0;
  logic [NI*SW-1:0] ret_seq = '0;
  logic [NI*DW-1:0] ret_data = '0;
  logic [NI-1:0]   ret_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
  logic [SW:0]     occupancy;
  logic            err;

  always #5 clk = ~clk;

  func_ret_rob #(.RET_DW(DW), .CALL_SEQ_W(SW), .INST_NUM(NI)) dut (
    .clk(clk), .rstn(rstn),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_seq(alloc_seq),
    .ret_valid(ret_valid), .ret_seq(ret_seq), .ret_data(ret_data), .ret_ready(ret_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        ordy;
    logic [3:0]  rv;
    logic [7:0]  rs;
    logic [127:0] rd;
    logic        gnt;
    logic [1:0]  aseq;
    logic [3:0]  rr;
    logic        ov;
    logic [31:0] od;
    logic [2:0]  occ;
    logic        er;
  } vec_t;

  vec_t tv[NV];

  function automatic vec_t v(input logic req, input logic ordy, input logic [3:0] rv,
                             input logic [7:0] rs, input logic [127:0] rd, input logic gnt,
                             input logic [1:0] aseq, input logic [3:0] rr, input logic ov,
                             input logic [31:0] od, input logic [2:0] occ, input logic er);
    vec_t t;
    t.req = req; t.ordy = ordy; t.rv = rv; t.rs = rs; t.rd = rd;
    t.gnt = gnt; t.aseq = aseq; t.rr = rr; t.ov = ov; t.od = od; t.occ = occ; t.er = er;
    return t;
  endfunction

  // Reference model: outstanding calls in allocation order.
  typedef struct {
    int          tag;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  bit   m_err;

  function automatic int find_tag(input int tag);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].tag == tag) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    alloc_req = 1'b0; ret_valid = '0; ret_seq = '0; ret_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mq.delete();
    m_tail = 0;
    m_err  = 1'b0;
  endtask

  task automatic rnd_cycle(input int cyc);
    logic [3:0]   rv;
    logic [7:0]   rs;
    logic [127:0] rd;
    logic [3:0]   e_rr;
    bit           req, ordy, e_gnt, e_ov;
    int           tag [NI];
    int           idx [NI];
    bit           legal [NI];
    bit           wr [NI];
    @(negedge clk);
    req  = ($urandom_range(0, 1) == 1);
    ordy = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < NI; i++) begin
      rv[i] = ($urandom_range(0, 3) == 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        tag[i] = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        tag[i] = $urandom_range(0, DEPTH - 1);
      rs[i*SW +: SW] = tag[i][SW-1:0];
      rd[i*DW +: DW] = $urandom;
    end
    alloc_req = req; out_ready = ordy; ret_valid = rv; ret_seq = rs; ret_data = rd;
    #1;
    e_ov = (mq.size() > 0) && mq[0].done;
    chk($sformatf("rnd%0d out_valid", cyc), out_valid, e_ov);
    if (e_ov) chk($sformatf("rnd%0d out_data", cyc), out_data, mq[0].data);
    chk($sformatf("rnd%0d occupancy", cyc), occupancy, mq.size());
    chk($sformatf("rnd%0d err", cyc), err, m_err);
    e_gnt = req && (mq.size() < DEPTH);
    chk($sformatf("rnd%0d alloc_gnt", cyc), alloc_gnt, e_gnt);
    chk($sformatf("rnd%0d alloc_seq", cyc), alloc_seq, m_tail);
    for (int i = 0; i < NI; i++) begin
      bit dup;
      idx[i]   = find_tag(tag[i]);
      legal[i] = rv[i] && (idx[i] >= 0) && !mq[idx[i] < 0 ? 0 : idx[i]].done;
      dup = 1'b0;
      for (int j = 0; j < i; j++) if (rv[j] && tag[j] == tag[i]) dup = 1'b1;
      wr[i]   = legal[i] && !dup;
      e_rr[i] = rv[i] && (!legal[i] || !dup);
    end
    chk($sformatf("rnd%0d ret_ready", cyc), ret_ready, e_rr);
    for (int i = 0; i < NI; i++) begin
      if (wr[i]) begin
        mq[idx[i]].done = 1'b1;
        mq[idx[i]].data = rd[i*DW +: DW];
      end
      if (rv[i] && !legal[i]) m_err = 1'b1;
    end
    if (e_ov && ordy) void'(mq.pop_front());
    if (e_gnt) begin
      ent_t e;
      e.tag = m_tail; e.done = 1'b0; e.data = '0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  initial begin
    tv[0]  = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 0, 4'b0000, 0, 32'h0, 0, 0);
    tv[1]  = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 1, 4'b0000, 0, 32'h0, 1, 0);
    tv[2]  = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 2, 4'b0000, 0, 32'h0, 2, 0);
    tv[3]  = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 3, 4'b0000, 0, 32'h0, 3, 0);
    tv[4]  = v(0, 1, 4'b0001, 8'h00, {96'h0, 32'hA0}, 0, 0, 4'b0001, 0, 32'h0, 4, 0);
    tv[5]  = v(0, 1, 4'b0001, 8'h01, {96'h0, 32'hA1}, 0, 0, 4'b0001, 1, 32'hA0, 4, 0);
    tv[6]  = v(0, 1, 4'b0001, 8'h02, {96'h0, 32'hA2}, 0, 0, 4'b0001, 1, 32'hA1, 3, 0);
    tv[7]  = v(0, 1, 4'b0001, 8'h03, {96'h0, 32'hA3}, 0, 0, 4'b0001, 1, 32'hA2, 2, 0);
    tv[8]  = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hA3, 1, 0);
    tv[9]  = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 0, 32'h0, 0, 0);
    tv[10] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 0, 4'b0000, 0, 32'h0, 0, 0);
    tv[11] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 1, 4'b0000, 0, 32'h0, 1, 0);
    tv[12] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 2, 4'b0000, 0, 32'h0, 2, 0);
    tv[13] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 3, 4'b0000, 0, 32'h0, 3, 0);
    tv[14] = v(0, 1, 4'b1110, 8'h6C, {32'hB1, 32'hB2, 32'hB3, 32'h0}, 0, 0, 4'b1110, 0, 32'h0, 4, 0);
    tv[15] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 0, 32'h0, 4, 0);
    tv[16] = v(0, 1, 4'b0001, 8'h00, {96'h0, 32'hB0}, 0, 0, 4'b0001, 0, 32'h0, 4, 0);
    tv[17] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hB0, 4, 0);
    tv[18] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hB1, 3, 0);
    tv[19] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hB2, 2, 0);
    tv[20] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hB3, 1, 0);
    tv[21] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 0, 32'h0, 0, 0);
    tv[22] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 0, 4'b0000, 0, 32'h0, 0, 0);
    tv[23] = v(1, 1, 4'b0000, 8'h00, 128'h0, 1, 1, 4'b0000, 0, 32'h0, 1, 0);
    tv[24] = v(0, 1, 4'b0101, 8'h11, {32'h0, 32'hD1, 32'h0, 32'hC1}, 0, 0, 4'b0001, 0, 32'h0, 2, 0);
    tv[25] = v(0, 1, 4'b0100, 8'h10, {32'h0, 32'hD1, 32'h0, 32'h0}, 0, 0, 4'b0100, 0, 32'h0, 2, 0);
    tv[26] = v(0, 1, 4'b0001, 8'h00, {96'h0, 32'hC0}, 0, 0, 4'b0001, 0, 32'h0, 2, 1);
    tv[27] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hC0, 2, 1);
    tv[28] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 1, 32'hC1, 1, 1);
    tv[29] = v(0, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 4'b0000, 0, 32'h0, 0, 1);

    // Reset state, with requests present to show outputs are held off.
    rstn = 1'b0; alloc_req = 1'b1; ret_valid = 4'b0001; ret_seq = 8'h00;
    #12;
    chk("rst alloc_gnt", alloc_gnt, 1'b0);
    chk("rst ret_ready", ret_ready, 4'b0000);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst occupancy", occupancy, 3'd0);
    chk("rst err", err, 1'b0);
    do_reset();

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      alloc_req = tv[k].req; out_ready = tv[k].ordy; ret_valid = tv[k].rv;
      ret_seq = tv[k].rs; ret_data = tv[k].rd;
      #1;
      chk($sformatf("vec%0d alloc_gnt", k), alloc_gnt, tv[k].gnt);
      if (tv[k].gnt) chk($sformatf("vec%0d alloc_seq", k), alloc_seq, tv[k].aseq);
      chk($sformatf("vec%0d ret_ready", k), ret_ready, tv[k].rr);
      chk($sformatf("vec%0d out_valid", k), out_valid, tv[k].ov);
      if (tv[k].ov) chk($sformatf("vec%0d out_data", k), out_data, tv[k].od);
      chk($sformatf("vec%0d occupancy", k), occupancy, tv[k].occ);
      chk($sformatf("vec%0d err", k), err, tv[k].er);
    end

    // Full and backpressure, then wrap of the tail on the next grant.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      alloc_req = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("full occupancy", occupancy, 3'd4);
    chk("full alloc_gnt", alloc_gnt, 1'b0);
    ret_valid = 4'b0001; ret_seq = 8'h00; ret_data = {96'h0, 32'h55};
    @(negedge clk);
    ret_valid = '0; out_ready = 1'b1;
    #1;
    chk("full out_valid", out_valid, 1'b1);
    chk("full out_data", out_data, 32'h55);
    chk("full no bypass gnt", alloc_gnt, 1'b0);
    @(negedge clk);
    #1;
    chk("wrap alloc_gnt", alloc_gnt, 1'b1);
    chk("wrap alloc_seq", alloc_seq, 2'd0);
    chk("wrap occupancy", occupancy, 3'd3);

    // Stray return on an empty ROB.
    do_reset();
    @(negedge clk);
    ret_valid = 4'b0001; ret_seq = 8'h02; ret_data = {96'h0, 32'hEE};
    #1;
    chk("stray ret_ready", ret_ready, 4'b0001);
    @(negedge clk);
    ret_valid = '0;
    #1;
    chk("stray err", err, 1'b1);
    chk("stray occupancy", occupancy, 3'd0);
    chk("stray out_valid", out_valid, 1'b0);

    // Mid-operation reset with outstanding tags and err set.
    do_reset();
    @(negedge clk);
    ret_valid = 4'b0001; ret_seq = 8'h03;
    @(negedge clk);
    ret_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alloc_req = 1'b1;
    end
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    chk("midrst pre occupancy", occupancy, 3'd3);
    chk("midrst pre err", err, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst occupancy", occupancy, 3'd0);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst err", err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    alloc_req = 1'b1;
    #1;
    chk("midrst alloc_gnt", alloc_gnt, 1'b1);
    chk("midrst alloc_seq", alloc_seq, 2'd0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rnd_cycle(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
